rle_trace_logger: RTL

Run-length trace logger that sits directly downstream of the PREP-style control state machine and consumes its 8-bit registered output code stream. Consecutive identical codes collapse into (value, run length) records, which are buffered in a small FIFO and drained by a debug or bus reader over a valid/ready handshake. Repeated idle codes (0x00) then cost one record per run instead of one per cycle. A sticky flag reports records lost to a full buffer.

---
 rtl/rle_trace_logger.sv | 125 ++++++++++++
 1 files changed

// File: rtl/rle_trace_logger.sv
// rtl/rle_trace_logger.sv - run-length trace logger with record FIFO
// Collapses repeated 8-bit codes into (code, count) records drained over valid/ready.
module rle_trace_logger #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         EN,
  input  logic [7:0]                   DIN,
  input  logic                         FLUSH,
  output logic                         REC_VALID,
  input  logic                         REC_READY,
  output logic [7:0]                   REC_DATA,
  output logic [CNT_W-1:0]             REC_COUNT,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL,
  output logic                         OVF
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = 8 + CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

  logic [7:0]       run_val_q, run_val_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             run_open_q, run_open_d;

  logic [RW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;

  logic             push_req;
  logic [RW-1:0]    push_rec;
  logic             pop;
  logic             push_ok;

  // Run tracker: decides whether the open run closes this cycle and what opens next.
  always_comb begin
    run_val_d  = run_val_q;
    run_cnt_d  = run_cnt_q;
    run_open_d = run_open_q;
    push_req   = 1'b0;
    push_rec   = {run_val_q, run_cnt_q};
    if (FLUSH) begin
      push_req = run_open_q;
      if (EN) begin
        run_val_d  = DIN;
        run_cnt_d  = CNT_ONE;
        run_open_d = 1'b1;
      end else begin
        run_open_d = 1'b0;
      end
    end else if (EN) begin
      if (!run_open_q) begin
        run_val_d  = DIN;
        run_cnt_d  = CNT_ONE;
        run_open_d = 1'b1;
      end else if (DIN == run_val_q && run_cnt_q != CNT_MAX) begin
        run_cnt_d = run_cnt_q + CNT_ONE;
      end else begin
        push_req  = 1'b1;
        run_val_d = DIN;
        run_cnt_d = CNT_ONE;
      end
    end
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  always_comb begin
    pop      = (level_q != '0) && REC_READY;
    push_ok  = push_req && ((level_q != LVL_FULL) || pop);
    ovf_d    = ovf_q | (push_req & ~push_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      run_val_q  <= '0;
      run_cnt_q  <= '0;
      run_open_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      run_val_q  <= run_val_d;
      run_cnt_q  <= run_cnt_d;
      run_open_q <= run_open_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_rec;
    end
  end

  assign REC_VALID = (level_q != '0);
  assign REC_DATA  = mem_q[rd_ptr_q][RW-1:CNT_W];
  assign REC_COUNT = mem_q[rd_ptr_q][CNT_W-1:0];
  assign LEVEL     = level_q;
  assign OVF       = ovf_q;

endmodule
